ttt_game_controller: RTL and testbench

- Sequencer for the tic-tac-toe board datapath. Consumes single-cycle button pulses and owns the player grids, cursor position and game state.
- Alternates turns, places marks, and detects win and draw.
- Its outputs feed the VGA renderer and the seven-segment status display at top level.
- Sits between the button debouncers and the display managers, in the 25 MHz or 100 MHz domain chosen by top level.

---
 rtl/ttt_pkg.sv | 56 +++++
 rtl/ttt_game_controller_if.sv | 26 ++
 rtl/ttt_win_detect.sv | 20 ++
 rtl/ttt_game_controller.sv | 126 ++++++++++++
 tb/tb_ttt_game_controller.sv | 239 +++++++++++++++++++++++
 5 files changed

// File: rtl/ttt_pkg.sv
// Shared encodings, win-line masks and small board helpers for the tic-tac-toe controller.
// Grids are MSB-first: cell 0 (top-left) sits in bit 8, cell 8 (bottom-right) in bit 0.
package ttt_pkg;

   localparam int BOARD_CELLS = 9;
   localparam int NUM_LINES   = 8;

   typedef enum logic [2:0] {
      GS_P1_TURN = 3'd0,
      GS_P2_TURN = 3'd1,
      GS_DRAW    = 3'd2,
      GS_P1_WIN  = 3'd3,
      GS_P2_WIN  = 3'd4
   } game_state_t;

   typedef enum logic [2:0] {
      P1_TURN  = 3'd0,
      P2_TURN  = 3'd1,
      P1_CHECK = 3'd2,
      P2_CHECK = 3'd3,
      DRAW     = 3'd4,
      P1_WIN   = 3'd5,
      P2_WIN   = 3'd6
   } fsm_state_t;

   // Rows, columns, then the two diagonals.
   localparam logic [NUM_LINES-1:0][BOARD_CELLS-1:0] LINE_MASKS = {
      9'b001010100,
      9'b100010001,
      9'b001001001,
      9'b010010010,
      9'b100100100,
      9'b000000111,
      9'b000111000,
      9'b111000000
   };

   function automatic logic [BOARD_CELLS-1:0] cell_mask(input logic [1:0] x, input logic [1:0] y);
      logic [BOARD_CELLS-1:0] top_bit;
      logic [3:0]             idx;
      top_bit = {1'b1, {(BOARD_CELLS-1){1'b0}}};
      idx     = ({2'b00, y} * 4'd3) + {2'b00, x};
      return top_bit >> idx;
   endfunction

   function automatic logic [1:0] coord_dec(input logic [1:0] c, input bit wrap);
      if (c == 2'd0) return wrap ? 2'd2 : 2'd0;
      return c - 2'd1;
   endfunction

   function automatic logic [1:0] coord_inc(input logic [1:0] c, input bit wrap);
      if (c >= 2'd2) return wrap ? 2'd0 : 2'd2;
      return c + 2'd1;
   endfunction

endpackage

// File: rtl/ttt_game_controller_if.sv
// Button pulses in, board/cursor/status out, between debouncers and display managers.
interface ttt_game_controller_if;
   import ttt_pkg::*;

   logic                   btn_u;
   logic                   btn_d;
   logic                   btn_l;
   logic                   btn_r;
   logic                   btn_s;
   logic [BOARD_CELLS-1:0] p1_grid;
   logic [BOARD_CELLS-1:0] p2_grid;
   logic [3:0]             cursor_pos;
   logic [2:0]             game_state;
   logic [3:0]             move_cnt;

   modport master (
      output btn_u, btn_d, btn_l, btn_r, btn_s,
      input  p1_grid, p2_grid, cursor_pos, game_state, move_cnt
   );

   modport slave (
      input  btn_u, btn_d, btn_l, btn_r, btn_s,
      output p1_grid, p2_grid, cursor_pos, game_state, move_cnt
   );

endinterface

// File: rtl/ttt_win_detect.sv
// Combinational line detector: high when the grid fully covers any of the 8 lines.
module ttt_win_detect
   import ttt_pkg::*;
(
   input  logic [BOARD_CELLS-1:0] grid,
   output logic                   win
);

   logic [NUM_LINES-1:0] line_hit;

   genvar gi;
   generate
      for (gi = 0; gi < NUM_LINES; gi = gi + 1) begin : g_line
         assign line_hit[gi] = ((grid & LINE_MASKS[gi]) == LINE_MASKS[gi]);
      end
   endgenerate

   assign win = |line_hit;

endmodule

// File: rtl/ttt_game_controller.sv
// Tic-tac-toe sequencer: turn alternation, mark placement, cursor motion, win/draw detection.
module ttt_game_controller
   import ttt_pkg::*;
#(
   parameter bit         CURSOR_WRAP  = 1'b1,
   parameter logic [3:0] RESET_CURSOR = 4'b0101
)(
   input  logic                  clk,
   input  logic                  rst,
   ttt_game_controller_if.slave  bus
);

   fsm_state_t             state_reg, state_next;
   logic [BOARD_CELLS-1:0] p1_grid_reg, p1_grid_next;
   logic [BOARD_CELLS-1:0] p2_grid_reg, p2_grid_next;
   logic [1:0]             cursor_x_reg, cursor_x_next;
   logic [1:0]             cursor_y_reg, cursor_y_next;
   logic [3:0]             move_cnt_reg, move_cnt_next;

   logic [BOARD_CELLS-1:0] sel_cell;
   logic                   cell_free;
   logic [BOARD_CELLS-1:0] mover_grid;
   logic                   mover_wins;
   logic [2:0]             game_state;

   assign sel_cell   = cell_mask(cursor_x_reg, cursor_y_reg);
   assign cell_free  = ((p1_grid_reg | p2_grid_reg) & sel_cell) == '0;
   assign mover_grid = (state_reg == P2_CHECK) ? p2_grid_reg : p1_grid_reg;

   ttt_win_detect u_win (
      .grid (mover_grid),
      .win  (mover_wins)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg    <= P1_TURN;
         p1_grid_reg  <= '0;
         p2_grid_reg  <= '0;
         cursor_x_reg <= RESET_CURSOR[3:2];
         cursor_y_reg <= RESET_CURSOR[1:0];
         move_cnt_reg <= 4'd0;
      end else begin
         state_reg    <= state_next;
         p1_grid_reg  <= p1_grid_next;
         p2_grid_reg  <= p2_grid_next;
         cursor_x_reg <= cursor_x_next;
         cursor_y_reg <= cursor_y_next;
         move_cnt_reg <= move_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      p1_grid_next  = p1_grid_reg;
      p2_grid_next  = p2_grid_reg;
      cursor_x_next = cursor_x_reg;
      cursor_y_next = cursor_y_reg;
      move_cnt_next = move_cnt_reg;
      case (state_reg)
         P1_TURN, P2_TURN: begin
            // One action per cycle; place outranks every move.
            if (bus.btn_s) begin
               if (cell_free) begin
                  if (state_reg == P1_TURN) begin
                     p1_grid_next = p1_grid_reg | sel_cell;
                     state_next   = P1_CHECK;
                  end else begin
                     p2_grid_next = p2_grid_reg | sel_cell;
                     state_next   = P2_CHECK;
                  end
                  move_cnt_next = move_cnt_reg + 4'd1;
               end
            end else if (bus.btn_u) begin
               cursor_y_next = coord_dec(cursor_y_reg, CURSOR_WRAP);
            end else if (bus.btn_d) begin
               cursor_y_next = coord_inc(cursor_y_reg, CURSOR_WRAP);
            end else if (bus.btn_l) begin
               cursor_x_next = coord_dec(cursor_x_reg, CURSOR_WRAP);
            end else if (bus.btn_r) begin
               cursor_x_next = coord_inc(cursor_x_reg, CURSOR_WRAP);
            end
         end
         P1_CHECK: begin
            if (mover_wins)                state_next = P1_WIN;
            else if (move_cnt_reg == 4'd9) state_next = DRAW;
            else                           state_next = P2_TURN;
         end
         P2_CHECK: begin
            if (mover_wins)                state_next = P2_WIN;
            else if (move_cnt_reg == 4'd9) state_next = DRAW;
            else                           state_next = P1_TURN;
         end
         DRAW, P1_WIN, P2_WIN: begin
            if (bus.btn_s) begin
               p1_grid_next  = '0;
               p2_grid_next  = '0;
               cursor_x_next = RESET_CURSOR[3:2];
               cursor_y_next = RESET_CURSOR[1:0];
               move_cnt_next = 4'd0;
               state_next    = P1_TURN;
            end
         end
         default: state_next = P1_TURN;
      endcase
   end

   always_comb begin
      game_state = GS_P1_TURN;
      case (state_reg)
         P1_TURN, P1_CHECK: game_state = GS_P1_TURN;
         P2_TURN, P2_CHECK: game_state = GS_P2_TURN;
         DRAW:              game_state = GS_DRAW;
         P1_WIN:            game_state = GS_P1_WIN;
         P2_WIN:            game_state = GS_P2_WIN;
         default:           game_state = GS_P1_TURN;
      endcase
   end

   assign bus.p1_grid    = p1_grid_reg;
   assign bus.p2_grid    = p2_grid_reg;
   assign bus.cursor_pos = {cursor_x_reg, cursor_y_reg};
   assign bus.game_state = game_state;
   assign bus.move_cnt   = move_cnt_reg;

endmodule

// File: tb/tb_ttt_game_controller.sv
// Bench: a wrapping and a saturating controller driven by the same buttons, each checked
// every cycle against a cell/line-level game model, plus hand-computed scenario checks.
module tb_ttt_game_controller;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic btn_u = 1'b0, btn_d = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_s = 1'b0;

   int n_vec = 0;
   int n_err = 0;
   bit started = 1'b0;

   always #5 clk = ~clk;

   ttt_game_controller_if bus_w ();
   ttt_game_controller_if bus_s ();

   assign bus_w.btn_u = btn_u;  assign bus_s.btn_u = btn_u;
   assign bus_w.btn_d = btn_d;  assign bus_s.btn_d = btn_d;
   assign bus_w.btn_l = btn_l;  assign bus_s.btn_l = btn_l;
   assign bus_w.btn_r = btn_r;  assign bus_s.btn_r = btn_r;
   assign bus_w.btn_s = btn_s;  assign bus_s.btn_s = btn_s;

   ttt_game_controller #(.CURSOR_WRAP(1'b1), .RESET_CURSOR(4'b0101)) dut_w (
      .clk (clk), .rst (rst), .bus (bus_w)
   );
   ttt_game_controller #(.CURSOR_WRAP(1'b0), .RESET_CURSOR(4'b0101)) dut_s (
      .clk (clk), .rst (rst), .bus (bus_s)
   );

   // Model: index 0 = wrapping instance, 1 = saturating instance.
   logic [8:0] m_p1 [2];
   logic [8:0] m_p2 [2];
   int m_x [2], m_y [2], m_gs [2], m_cnt [2];
   bit m_chk [2];

   int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                        '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

   function automatic bit owns(logic [8:0] g, int c);
      return g[8-c];
   endfunction

   function automatic bit has_line(logic [8:0] g);
      for (int l = 0; l < 8; l++)
         if (owns(g, lines[l][0]) && owns(g, lines[l][1]) && owns(g, lines[l][2])) return 1'b1;
      return 1'b0;
   endfunction

   function automatic int mdec(int v, bit wrap);
      if (v == 0) return wrap ? 2 : 0;
      return v - 1;
   endfunction

   function automatic int minc(int v, bit wrap);
      if (v == 2) return wrap ? 0 : 2;
      return v + 1;
   endfunction

   function automatic void model_clear(int k);
      m_p1[k] = '0; m_p2[k] = '0; m_x[k] = 1; m_y[k] = 1;
      m_gs[k] = 0; m_cnt[k] = 0; m_chk[k] = 1'b0;
   endfunction

   function automatic void model_step(int k, bit r_i, bit u, bit d, bit l, bit r, bit s);
      bit wrap;
      int c;
      wrap = (k == 0);
      if (r_i) begin
         model_clear(k);
      end else if (m_chk[k]) begin
         m_chk[k] = 1'b0;
         if (has_line(m_gs[k] == 0 ? m_p1[k] : m_p2[k])) m_gs[k] = (m_gs[k] == 0) ? 3 : 4;
         else if (m_cnt[k] == 9)                          m_gs[k] = 2;
         else                                             m_gs[k] = 1 - m_gs[k];
      end else if (m_gs[k] >= 2) begin
         if (s) model_clear(k);
      end else if (s) begin
         c = 3 * m_y[k] + m_x[k];
         if (!owns(m_p1[k], c) && !owns(m_p2[k], c)) begin
            if (m_gs[k] == 0) m_p1[k][8-c] = 1'b1;
            else              m_p2[k][8-c] = 1'b1;
            m_cnt[k] = m_cnt[k] + 1;
            m_chk[k] = 1'b1;
         end
      end else if (u) m_y[k] = mdec(m_y[k], wrap);
      else if (d)     m_y[k] = minc(m_y[k], wrap);
      else if (l)     m_x[k] = mdec(m_x[k], wrap);
      else if (r)     m_x[k] = minc(m_x[k], wrap);
   endfunction

   always @(posedge clk) begin
      if (rst) started = 1'b1;
      if (started)
         for (int k = 0; k < 2; k++) model_step(k, rst, btn_u, btn_d, btn_l, btn_r, btn_s);
   end

   function automatic void cmp(string name, int k, int act, int exp_v);
      n_vec++;
      if (act != exp_v) begin
         n_err++;
         $display("FAIL %s[%0d] at %0t: got %0h expected %0h", name, k, $time, act, exp_v);
      end
   endfunction

   // Compare process: both instances against the model on every falling edge.
   always @(negedge clk) begin
      if (started) begin
         cmp("p1_grid",    0, int'(bus_w.p1_grid),    int'(m_p1[0]));
         cmp("p2_grid",    0, int'(bus_w.p2_grid),    int'(m_p2[0]));
         cmp("cursor_pos", 0, int'(bus_w.cursor_pos), m_x[0] * 4 + m_y[0]);
         cmp("game_state", 0, int'(bus_w.game_state), m_gs[0]);
         cmp("move_cnt",   0, int'(bus_w.move_cnt),   m_cnt[0]);
         cmp("disjoint",   0, int'(bus_w.p1_grid & bus_w.p2_grid), 0);
         cmp("p1_grid",    1, int'(bus_s.p1_grid),    int'(m_p1[1]));
         cmp("p2_grid",    1, int'(bus_s.p2_grid),    int'(m_p2[1]));
         cmp("cursor_pos", 1, int'(bus_s.cursor_pos), m_x[1] * 4 + m_y[1]);
         cmp("game_state", 1, int'(bus_s.game_state), m_gs[1]);
         cmp("move_cnt",   1, int'(bus_s.move_cnt),   m_cnt[1]);
         cmp("disjoint",   1, int'(bus_s.p1_grid & bus_s.p2_grid), 0);
      end
   end

   task automatic press(bit u, bit d, bit l, bit r, bit s);
      btn_u = u; btn_d = d; btn_l = l; btn_r = r; btn_s = s;
      @(negedge clk);
      btn_u = 1'b0; btn_d = 1'b0; btn_l = 1'b0; btn_r = 1'b0; btn_s = 1'b0;
      $display("txn u=%0b d=%0b l=%0b r=%0b s=%0b -> cur=%b gs=%0d cnt=%0d p1=%b p2=%b",
               u, d, l, r, s, bus_w.cursor_pos, bus_w.game_state, bus_w.move_cnt,
               bus_w.p1_grid, bus_w.p2_grid);
   endtask

   task automatic idle(int n);
      for (int i = 0; i < n; i++) press(0, 0, 0, 0, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic goto_cell(int x, int y);
      for (int i = 0; i < 4 && m_x[0] != x; i++)
         if (m_x[0] < x) press(0, 0, 0, 1, 0); else press(0, 0, 1, 0, 0);
      for (int i = 0; i < 4 && m_y[0] != y; i++)
         if (m_y[0] < y) press(0, 1, 0, 0, 0); else press(1, 0, 0, 0, 0);
   endtask

   task automatic place(int c);
      goto_cell(c % 3, c / 3);
      press(0, 0, 0, 0, 1);
      idle(1);
   endtask

   int draw_seq [9] = '{0, 1, 2, 4, 3, 5, 7, 6, 8};

   initial begin
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      // Reset state.
      cmp("lit_rst_cursor", 0, int'(bus_w.cursor_pos), 'b0101);
      cmp("lit_rst_state",  0, int'(bus_w.game_state), 0);
      cmp("lit_rst_grid",   0, int'(bus_w.p1_grid | bus_w.p2_grid), 0);
      cmp("lit_rst_cnt",    1, int'(bus_s.move_cnt), 0);

      // Right edge: wrap vs saturate.
      press(0, 0, 0, 1, 0);
      cmp("lit_r1_cursor", 0, int'(bus_w.cursor_pos), 'b1001);
      press(0, 0, 0, 1, 0);
      cmp("lit_wrap",      0, int'(bus_w.cursor_pos), 'b0001);
      cmp("lit_saturate",  1, int'(bus_s.cursor_pos), 'b1001);

      // P1 top-row win.
      do_reset();
      place(0); place(3); place(1); place(4); place(2);
      cmp("lit_win_p1grid", 0, int'(bus_w.p1_grid), 'b111000000);
      cmp("lit_win_p2grid", 0, int'(bus_w.p2_grid), 'b000110000);
      cmp("lit_win_state",  0, int'(bus_w.game_state), 3);
      press(0, 0, 1, 0, 0);
      press(0, 1, 0, 0, 0);
      cmp("lit_frozen_cursor", 0, int'(bus_w.cursor_pos), 'b1000);
      cmp("lit_frozen_cnt",    0, int'(bus_w.move_cnt), 5);

      // Restart then play to a draw.
      press(0, 0, 0, 0, 1);
      cmp("lit_restart_state", 0, int'(bus_w.game_state), 0);
      for (int i = 0; i < 9; i++) place(draw_seq[i]);
      cmp("lit_draw_state",  0, int'(bus_w.game_state), 2);
      cmp("lit_draw_cnt",    0, int'(bus_w.move_cnt), 9);
      cmp("lit_draw_p1grid", 0, int'(bus_w.p1_grid), 'b101100011);
      cmp("lit_draw_p2grid", 0, int'(bus_w.p2_grid), 'b010011100);
      press(0, 0, 0, 0, 1);
      cmp("lit_clear_grid",   0, int'(bus_w.p1_grid | bus_w.p2_grid), 0);
      cmp("lit_clear_cursor", 0, int'(bus_w.cursor_pos), 'b0101);
      cmp("lit_clear_cnt",    0, int'(bus_w.move_cnt), 0);

      // Placing on an occupied cell is ignored.
      place(4);
      press(0, 0, 0, 0, 1);
      idle(1);
      cmp("lit_occ_state",  0, int'(bus_w.game_state), 1);
      cmp("lit_occ_cnt",    0, int'(bus_w.move_cnt), 1);
      cmp("lit_occ_p1grid", 0, int'(bus_w.p1_grid), 'b000010000);
      cmp("lit_occ_p2grid", 0, int'(bus_w.p2_grid), 0);

      // Place outranks a simultaneous move.
      do_reset();
      press(1, 0, 0, 0, 1);
      cmp("lit_prio_cursor", 0, int'(bus_w.cursor_pos), 'b0101);
      cmp("lit_prio_p1grid", 0, int'(bus_w.p1_grid), 'b000010000);
      idle(1);

      // Reset while P2's move is being checked.
      goto_cell(0, 0);
      press(0, 0, 0, 0, 1);
      cmp("lit_p2chk_p2grid", 0, int'(bus_w.p2_grid), 'b100000000);
      cmp("lit_p2chk_state",  0, int'(bus_w.game_state), 1);
      do_reset();
      cmp("lit_midrst_grid",  0, int'(bus_w.p1_grid | bus_w.p2_grid), 0);
      cmp("lit_midrst_cnt",   0, int'(bus_w.move_cnt), 0);
      cmp("lit_midrst_state", 0, int'(bus_w.game_state), 0);

      // Random play; the compare process checks every cycle.
      for (int i = 0; i < 3000; i++) begin
         rst = ($urandom_range(0, 299) == 0);
         press($urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
               $urandom_range(0, 3) == 0);
         rst = 1'b0;
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
